// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state enum, opcodes and
// datapath select codes used by the FSM, the immediate decoder and the datapath.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // States that stall on the memory handshake and feed the watchdog.
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control strobes,
// datapath selects and status out. The controller side is the master.
interface mc_ctrl_fsm_if;
    logic [6:0] iop;
    logic       imem_rdy;
    logic       opc_update;
    logic       oir_wr;
    logic       oadr_src;
    logic       omem_wr;
    logic       oreg_wr;
    logic       obranch;
    logic [1:0] oalu_src_a;
    logic [1:0] oalu_src_b;
    logic [1:0] oresult_src;
    logic [1:0] oalu_op;
    logic [2:0] oimm_src;
    logic [3:0] ostate;
    logic       otrap;

    modport master (
        input  iop, imem_rdy,
        output opc_update, oir_wr, oadr_src, omem_wr, oreg_wr, obranch,
               oalu_src_a, oalu_src_b, oresult_src, oalu_op, oimm_src, ostate, otrap
    );

    modport slave (
        output iop, imem_rdy,
        input  opc_update, oir_wr, oadr_src, omem_wr, oreg_wr, obranch,
               oalu_src_a, oalu_src_b, oresult_src, oalu_op, oimm_src, ostate, otrap
    );
endinterface

// File: rtl/mc_ctrl_fsm_imm_dec.sv
// Opcode to immediate-format decode; purely combinational, unknown opcodes map to I.
module imm_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [2:0] o_imm_src
);

    always_comb begin
        case (i_op)
            OP_STORE:         o_imm_src = IMM_S;
            OP_BRANCH:        o_imm_src = IMM_B;
            OP_JAL:           o_imm_src = IMM_J;
            OP_LUI, OP_AUIPC: o_imm_src = IMM_U;
            default:          o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM with a memory-wait watchdog that parks the core in
// a sticky TRAP state; TRAP is left only through reset.
module mc_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = 255,
    parameter bit          P_MEM_HS  = 1'b1
) (
    input  logic          iclk,
    input  logic          irst_n,
    mc_ctrl_fsm_if.master bus
);

    localparam int unsigned         LP_CNT_W    = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [LP_CNT_W-1:0] r_wait_cnt;
    logic                w_rdy;
    logic                w_waiting;
    logic                w_timeout;
    logic [2:0]          w_imm_src;

    assign w_rdy     = P_MEM_HS ? bus.imem_rdy : 1'b1;
    assign w_waiting = is_mem_wait(r_state) && !w_rdy;
    // Fires in the cycle whose increment would reach P_TIMEOUT; a ready in that
    // same cycle clears w_waiting, so completion always beats the trap.
    assign w_timeout = (P_TIMEOUT != 0) && w_waiting && (r_wait_cnt == LP_CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) r_state <= S_FETCH;
        else         r_state <= w_next;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n)                              r_wait_cnt <= '0;
        else if (w_waiting && (w_next == r_state)) r_wait_cnt <= r_wait_cnt + LP_CNT_W'(1);
        else                                      r_wait_cnt <= '0;
    end

    // NOTE: every output and the next state get a default before the case, so no
    // path through the block leaves a value unassigned and infers a latch.
    always_comb begin
        w_next          = r_state;
        bus.opc_update  = 1'b0;
        bus.oir_wr      = 1'b0;
        bus.oadr_src    = 1'b0;
        bus.omem_wr     = 1'b0;
        bus.oreg_wr     = 1'b0;
        bus.obranch     = 1'b0;
        bus.oalu_src_a  = SRC_A_PC;
        bus.oalu_src_b  = SRC_B_RS2;
        bus.oresult_src = RES_ALUOUT;
        bus.oalu_op     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                bus.oalu_src_b  = SRC_B_FOUR;
                bus.oresult_src = RES_ALURESULT;
                bus.oir_wr      = w_rdy;
                bus.opc_update  = w_rdy;
                if (w_rdy)          w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                bus.oalu_src_a = SRC_A_OLDPC;
                bus.oalu_src_b = SRC_B_IMM;
                case (bus.iop)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.oalu_src_a = SRC_A_RS1;
                bus.oalu_src_b = SRC_B_IMM;
                w_next         = (bus.iop == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.oadr_src = 1'b1;
                if (w_rdy)          w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWB: begin
                bus.oresult_src = RES_READDATA;
                bus.oreg_wr     = 1'b1;
                w_next          = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.oadr_src = 1'b1;
                bus.omem_wr  = 1'b1;
                if (w_rdy)          w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_EXECR: begin
                bus.oalu_src_a = SRC_A_RS1;
                bus.oalu_src_b = SRC_B_RS2;
                bus.oalu_op    = ALU_FUNCT;
                w_next         = S_ALUWB;
            end
            S_EXECI: begin
                bus.oalu_src_a = SRC_A_RS1;
                bus.oalu_src_b = SRC_B_IMM;
                bus.oalu_op    = ALU_FUNCT;
                w_next         = S_ALUWB;
            end
            S_LUI: begin
                bus.oalu_src_a = SRC_A_ZERO;
                bus.oalu_src_b = SRC_B_IMM;
                w_next         = S_ALUWB;
            end
            S_AUIPC: begin
                bus.oalu_src_a = SRC_A_OLDPC;
                bus.oalu_src_b = SRC_B_IMM;
                w_next         = S_ALUWB;
            end
            S_ALUWB: begin
                bus.oreg_wr = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                bus.oalu_src_a = SRC_A_RS1;
                bus.oalu_src_b = SRC_B_RS2;
                bus.oalu_op    = ALU_BRANCH;
                bus.obranch    = 1'b1;
                w_next         = S_FETCH;
            end
            S_JAL: begin
                bus.oalu_src_a = SRC_A_OLDPC;
                bus.oalu_src_b = SRC_B_FOUR;
                bus.opc_update = 1'b1;
                w_next         = S_ALUWB;
            end
            S_JALR: begin
                bus.oalu_src_a  = SRC_A_RS1;
                bus.oalu_src_b  = SRC_B_IMM;
                bus.oresult_src = RES_ALURESULT;
                bus.opc_update  = 1'b1;
                w_next          = S_JALRWB;
            end
            S_JALRWB: begin
                bus.oalu_src_a  = SRC_A_OLDPC;
                bus.oalu_src_b  = SRC_B_FOUR;
                bus.oresult_src = RES_ALURESULT;
                bus.oreg_wr     = 1'b1;
                w_next          = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
        endcase
    end

    imm_dec u_imm_dec (
        .i_op      (bus.iop),
        .o_imm_src (w_imm_src)
    );

    assign bus.oimm_src = w_imm_src;
    assign bus.ostate   = r_state;
    assign bus.otrap    = (r_state == S_TRAP);

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter P_TIMEOUT, default 255: maximum memory-wait cycles before trap; 0 disables the watchdog.
REQ-002 SHALL have parameter P_MEM_HS, default 1: 1 = honour imem_rdy; 0 = treat it as constant 1.
REQ-003 iclk  in  1  single clock, rising edge.
REQ-004 irst_n  in  1  reset, asynchronous, active-low.
REQ-005 iop  in  7  opcode of the latched instruction (IR[6:0]).
REQ-006 imem_rdy  in  1  memory access completes this cycle.
REQ-007 opc_update  out  1  PC register write enable.
REQ-008 oir_wr  out  1  instruction register and OldPC write enable.
REQ-009 oadr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 omem_wr  out  1  data memory write.
REQ-011 oreg_wr  out  1  register file write.
REQ-012 obranch  out  1  branch evaluation cycle.
REQ-013 oalu_src_a  out  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
REQ-014 oalu_src_b  out  2  ALU operand B: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-015 oresult_src  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult.
REQ-016 oalu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-017 oimm_src  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100; combinational from iop; 000 for unknown opcodes.
REQ-018 ostate  out  4  current state encoding; otrap  out  1  sticky trap flag.

Function
REQ-019 States (4-bit encoding, in package order) SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, AUIPC, TRAP.
REQ-020 All outputs are Moore outputs of the state, except oir_wr, opc_update, and the memory wait gating, which also depend on imem_rdy; every output is 0 unless listed below.
REQ-021 FETCH SHALL drive adr_src = 0, src_a = 00, src_b = 10, alu_op = 00, result_src = 10; oir_wr and opc_update = imem_rdy; it holds FETCH until imem_rdy, then goes to DECODE.
REQ-022 DECODE SHALL drive src_a = 01, src_b = 01, alu_op = 00; next state by iop:
  - load 0000011 / store 0100011 -> MEMADR
  - R-type 0110011 -> EXECR
  - I-type 0010011 -> EXECI
  - branch 1100011 -> BRANCH
  - jal 1101111 -> JAL
  - jalr 1100111 -> JALR
  - lui 0110111 -> LUI
  - auipc 0010111 -> AUIPC
  - any other opcode -> TRAP
REQ-023 MEMADR SHALL drive src_a = 10, src_b = 01; next is MEMREAD for load, MEMWRITE for store.
REQ-024 MEMREAD SHALL drive adr_src = 1; it holds until imem_rdy, then goes to MEMWB.
REQ-025 MEMWB SHALL drive result_src = 01, reg_wr = 1; next is FETCH.
REQ-026 MEMWRITE SHALL drive adr_src = 1 and omem_wr = 1 every cycle until imem_rdy; next is FETCH.
REQ-027 EXECR SHALL drive src_a = 10, src_b = 00, alu_op = 10; EXECI SHALL drive src_a = 10, src_b = 01, alu_op = 10; LUI SHALL drive src_a = 11, src_b = 01; AUIPC SHALL drive src_a = 01, src_b = 01. All four go next to ALUWB.
REQ-028 ALUWB SHALL drive result_src = 00, reg_wr = 1; next is FETCH.
REQ-029 BRANCH SHALL drive src_a = 10, src_b = 00, alu_op = 01, result_src = 00, obranch = 1; next is FETCH.
REQ-030 JAL SHALL drive src_a = 01, src_b = 10, result_src = 00, opc_update = 1; next is ALUWB.
REQ-031 JALR SHALL drive src_a = 10, src_b = 01, result_src = 10, opc_update = 1; next is JALRWB.
REQ-032 JALRWB SHALL drive src_a = 01, src_b = 10, result_src = 10, reg_wr = 1; next is FETCH.
REQ-033 Watchdog:
  - a $clog2(P_TIMEOUT+1)-bit counter increments each cycle spent in FETCH, MEMREAD or MEMWRITE with imem_rdy = 0;
  - it clears on imem_rdy = 1 and on any state change;
  - reaching P_TIMEOUT SHALL move the FSM to TRAP on the next edge;
  - if imem_rdy rises in that same cycle, completion wins.
REQ-034 TRAP SHALL hold all enables at 0 and otrap = 1; it is left only by reset.

Reset
REQ-035 While irst_n = 0, the state SHALL be FETCH and the watchdog counter and otrap SHALL be 0, asynchronously; the first FETCH cycle begins on the first edge after release.
REQ-036 Reset asserted mid-instruction SHALL abort it with no further reg_wr or mem_wr.

Structure
REQ-037 The state enum, the opcode constants and the src/result/imm encodings SHALL live in a shared package, rv_ctrl_pkg.
REQ-038 Opcode-to-imm_src decode SHALL be one sub-module, imm_dec.

Verification
REQ-039 R-type (iop 0110011), imem_rdy = 1 always: ostate sequence FETCH, DECODE, EXECR, ALUWB, FETCH; reg_wr = 1 only in ALUWB.
REQ-040 Load with imem_rdy low 3 cycles in MEMREAD: MEMREAD held 4 cycles, then MEMWB with result_src = 01.
REQ-041 Store: omem_wr = 1 only in MEMWRITE, oimm_src = 001, reg_wr never asserted.
REQ-042 jalr: JALR has opc_update = 1 and result_src = 10, JALRWB has reg_wr = 1 and src_b = 10.
REQ-043 Illegal opcode 1111111 -> TRAP, otrap = 1; with P_TIMEOUT = 4 and imem_rdy stuck 0 in FETCH, TRAP is reached after 4 wait cycles.
REQ-044 irst_n pulsed low during MEMWRITE: omem_wr drops immediately, ostate = FETCH.
